matrix_seq: RTL
===============

Name: matrix_seq

Overview:
- Sequencer directly upstream of the matrix datapath: generates its RAM select, address, write-data and write-enable signals, and consumes its read data.
- LOAD: streams 32-bit elements from an input valid/ready stream into a contiguous row range of the 1024x1024 matrix, in row-major order.
- DUMP: reads the same kind of range back out onto an output valid/ready stream.

Parameters:
- NROW_W, 10, row index width (1024 rows)
- NCOL_W, 10, column index width (1024 columns)
- DW, 32, element width

Ports:
- CLK  in  1  clock; single clock domain
- RST  in  1  synchronous reset, active-high
- load_start  in  1  pulse: begin LOAD of rows row_first..row_last
- dump_start  in  1  pulse: begin DUMP of rows row_first..row_last
- row_first  in  10  first row; sampled on an accepted start
- row_last  in  10  last row, inclusive; sampled on an accepted start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when an operation ends
- err  out  1  one-cycle pulse together with done when the range is illegal
- s_valid  in  1  input stream valid
- s_ready  out  1  input stream ready
- s_data  in  32  input element
- m_valid  out  1  output stream valid
- m_ready  in  1  output stream ready
- m_data  out  32  output element
- dp_ram_sel  out  16  one-hot RAM select to the datapath
- dp_a  out  16  RAM address to the datapath
- dp_din  out  32  write data to the datapath
- dp_we  out  16  per-RAM write enable to the datapath
- dp_dout  in  32  datapath read data; combinational from dp_ram_sel and dp_a

Behaviour:
- Address map: element index = {row, col}, 20 bits.
  - RAM number = row[9:6]; dp_ram_sel = 1 << row[9:6].
  - dp_a = {row[5:0], col}.
  - row and col are the internal registered counters.
- Counter advance: col increments 0..1023. At col = 1023, col wraps to 0 and row increments.
  - The last element is (row_last, 1023).
  - Element count = (row_last - row_first + 1) * 1024.
- States: IDLE, LOAD, DUMP, DRAIN.
- IDLE:
  - load_start takes priority if both starts are high.
  - On an accepted start: latch row_first and row_last; row <= row_first; col <= 0.
  - If row_first > row_last: stay in IDLE and pulse done and err the next cycle. No datapath access occurs.
  - Otherwise go to LOAD or DUMP.
  - Starts are ignored whenever busy = 1.
- LOAD:
  - s_ready = 1. dp_din = s_data.
  - dp_we = dp_ram_sel when s_valid = 1, else 0.
  - The write is combinational from s_valid; the datapath captures it at the clock edge.
  - Each handshake advances the counters.
  - The handshake on the last element goes to IDLE and pulses done the next cycle.
  - s_ready = 0 in every other state.
- DUMP:
  - Output register with 1-entry capacity.
  - When !m_valid || m_ready: m_data <= dp_dout, m_valid <= 1, counters advance.
  - Loading the last element goes to DRAIN.
- DRAIN:
  - Hold m_valid and m_data until m_ready is seen.
  - Then m_valid <= 0, go to IDLE, pulse done the same edge.
  - Throughput is 1 element/cycle with m_ready held high.
  - m_data must not change while m_valid && !m_ready.
- dp_we = 0 outside LOAD. dp_ram_sel and dp_a always reflect the counters.
- Reset values: state IDLE, row 0, col 0, busy 0, done 0, err 0, s_ready 0, m_valid 0, m_data 0, dp_we 0, dp_din 0 in reset. dp_ram_sel = 16'h0001 and dp_a = 0 follow from the reset counters.
- Reset mid-operation:
  - Aborts with no done pulse.
  - A write in the reset cycle is suppressed: dp_we forced to 0 while RST = 1.
  - A pending m_valid is dropped.

Test Plan:
- Reset, then LOAD row_first = row_last = 0 with s_valid held high, s_data = col -> 1024 writes with dp_ram_sel = 16'h0001 and dp_a = 0..1023. done pulses 1 cycle after the final handshake; busy falls in the same cycle.
- LOAD rows 63..64 -> write #1024 is at (row 63, col 1023): dp_ram_sel = 16'h0001, dp_a = 16'hFFFF. The next write is at (row 64, col 0): dp_ram_sel = 16'h0002, dp_a = 0. Total 2048 writes.
- DUMP rows 63..64 after the prior load, with m_ready toggling randomly -> 2048 outputs in order, values equal to the loaded data. No duplicates or drops; m_data stable while stalled.
- LOAD with random s_valid gaps; load_start and dump_start pulsed mid-operation -> writes occur only on valid cycles and the starts are ignored.
- row_first = 5, row_last = 4 -> no dp_we. done and err pulse together the cycle after the start; busy stays 0.
- Assert RST for 1 cycle during LOAD element 10 -> no dp_we in the reset cycle, no done pulse. All outputs hold their reset values; a new LOAD starts at col 0.

Source files
------------

// File: rtl/matrix_seq.sv
// Sequencer for the 1024x1024 matrix datapath: LOADs a row range from an input stream
// into the RAM bank array and DUMPs a row range back out through a 1-entry output register.
module matrix_seq #(
    parameter int NROW_W = 10,
    parameter int NCOL_W = 10,
    parameter int DW     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_start,
    input  logic              dump_start,
    input  logic [NROW_W-1:0] row_first,
    input  logic [NROW_W-1:0] row_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic [15:0]       dp_ram_sel,
    output logic [15:0]       dp_a,
    output logic [DW-1:0]     dp_din,
    output logic [15:0]       dp_we,
    input  logic [DW-1:0]     dp_dout
);

    localparam int RAM_W = NROW_W - 6;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DUMP, S_DRAIN} state_t;

    state_t            r_state;
    logic [NROW_W-1:0] r_row;
    logic [NROW_W-1:0] r_row_last;
    logic [NCOL_W-1:0] r_col;
    logic              r_done;
    logic              r_err;
    logic              r_m_valid;
    logic [DW-1:0]     r_m_data;

    logic w_last;
    logic w_load_hs;
    logic w_dump_adv;
    logic w_adv;

    assign w_last     = (r_row == r_row_last) && (r_col == '1);
    assign w_load_hs  = (r_state == S_LOAD) && s_valid;
    assign w_dump_adv = (r_state == S_DUMP) && (!r_m_valid || m_ready);
    assign w_adv      = w_load_hs || w_dump_adv;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_row_last <= '0;
            r_col      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_adv) begin
                r_col <= r_col + 1'b1;
                if (r_col == '1)
                    r_row <= r_row + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (load_start || dump_start) begin
                        r_row_last <= row_last;
                        r_row      <= row_first;
                        r_col      <= '0;
                        // An inverted range is reported without touching the datapath.
                        if (row_first > row_last) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else if (load_start) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_state <= S_DUMP;
                        end
                    end
                end
                S_LOAD: begin
                    if (s_valid && w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                S_DUMP: begin
                    if (w_dump_adv) begin
                        r_m_data  <= dp_dout;
                        r_m_valid <= 1'b1;
                        if (w_last)
                            r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= S_IDLE;
                        r_done    <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign err     = r_err;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

    // Gating with RST keeps a write from landing in the datapath during a reset cycle.
    assign s_ready = (r_state == S_LOAD) && !RST;
    assign dp_din  = s_ready ? s_data : '0;
    assign dp_a    = {r_row[5:0], r_col};

    generate
        for (genvar gi = 0; gi < (1 << RAM_W); gi++) begin : g_ram
            assign dp_ram_sel[gi] = (r_row[NROW_W-1:6] == RAM_W'(gi));
            assign dp_we[gi]      = s_ready && s_valid && dp_ram_sel[gi];
        end
    endgenerate

endmodule
